// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between in-order writeback (A) and a queued long-latency stream (B).
// Optional RF_ARB_R0_DROP_EN: writes to register 0 are consumed without reaching the register file.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_we,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_addr,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   b_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {NORMAL, DRAIN} state_t;
  state_t state, stateNext;

  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];
  logic [DEPTH-1:0]  entVld;
  logic [PW-1:0]     headPtr, tailPtr;
  logic [CW-1:0]     count;
  logic [WW-1:0]     waitCnt;

  logic             empty, push, aIssue, headDrop, headDead, pop, bIssue;
  logic [DEPTH-1:0] killMask, popMask, pushMask;

  assign empty     = (count == '0);
  assign b_ready   = (count != CW'(DEPTH));
  assign b_count   = count;
  assign stall_req = (state == DRAIN);
  assign push      = b_valid && b_ready;

`ifdef RF_ARB_R0_DROP_EN
  assign aIssue   = a_we && (a_addr != '0);
  assign headDrop = (entAddr[headPtr] == '0);
`else
  assign aIssue   = a_we;
  assign headDrop = 1'b0;
`endif

  // A is younger in program order, so any queued write to the same register is stale.
  always_comb begin
    killMask = '0;
    for (int i = 0; i < DEPTH; i++)
      killMask[i] = aIssue && entVld[i] && (entAddr[i] == a_addr);
  end

  // A dead head still takes the B slot even while A is issuing.
  assign headDead = !entVld[headPtr] || killMask[headPtr] || headDrop;
  assign pop      = !empty && (headDead || !aIssue);
  assign bIssue   = pop && !headDead;

  always_comb begin
    popMask  = '0;
    pushMask = '0;
    if (pop)  popMask[headPtr]  = 1'b1;
    if (push) pushMask[tailPtr] = 1'b1;
  end

  always_comb begin
    stateNext = state;
    case (state)
      NORMAL: if (waitCnt == WW'(MAX_WAIT)) stateNext = DRAIN;
      DRAIN:  if (empty) stateNext = NORMAL;
      default: stateNext = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entAddr[tailPtr] <= b_addr;
      entData[tailPtr] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= NORMAL;
      entVld  <= '0;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      waitCnt <= '0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      state   <= stateNext;
      // Same-cycle push lands after the kill so it survives.
      entVld  <= (entVld & ~killMask & ~popMask) | pushMask;
      if (pop)  headPtr <= headPtr + 1'b1;
      if (push) tailPtr <= tailPtr + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      if (empty || pop)
        waitCnt <= '0;
      else if (waitCnt != WW'(MAX_WAIT))
        waitCnt <= waitCnt + 1'b1;
      if (aIssue) begin
        rf_we   <= 1'b1;
        rf_addr <= a_addr;
        rf_data <= a_data;
      end else if (bIssue) begin
        rf_we   <= 1'b1;
        rf_addr <= entAddr[headPtr];
        rf_data <= entData[headPtr];
      end else begin
        rf_we   <= 1'b0;
      end
    end
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order writeback stream (port A, from the MEM/WB stage) and a long-latency result stream (port B, e.g. multi-cycle multiply/divide or late load data). Port A always wins, and port B results queue in a small FIFO. A starvation timer forces a pipeline drain so that queued results retire. The block sits between the writeback stage and the decode-stage register file and drives that file's write enable, address and data.

## Interface
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register address width (32 registers).
- `DEPTH`, default 4: port-B FIFO entries; must be a power of 2, minimum 2.
- `MAX_WAIT`, default 8: consecutive cycles a nonempty FIFO may go unserved before a drain is forced; must be at least 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_we`  in  1  writeback write request; never back-pressured.
- `a_addr`  in  ADDR_W  writeback destination register.
- `a_data`  in  DATA_W  writeback data.
- `b_valid`  in  1  long-latency result valid.
- `b_ready`  out  1  FIFO can accept; equals not full.
- `b_addr`  in  ADDR_W  long-latency destination register.
- `b_data`  in  DATA_W  long-latency data.
- `rf_we`  out  1  register file write enable (registered).
- `rf_addr`  out  ADDR_W  register file write address (registered).
- `rf_data`  out  DATA_W  register file write data (registered).
- `stall_req`  out  1  request for the pipeline to stop issuing port-A writes.
- `b_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push.** A transfer occurs when `b_valid && b_ready`. The entry is written at the tail.
- **Issue priority, each cycle.**
  - If `a_we` is high, issue A.
  - Otherwise, if the FIFO is nonempty, issue the head entry and pop it.
  - Otherwise, `rf_we` is 0 on the next cycle.
- **Kill rule.** When A is issued, every stored entry whose address equals `a_addr` is invalidated, because A is program-order younger.
  - An entry pushed in the same cycle is not killed.
  - A killed head is popped without issue and consumes the cycle's B slot. Non-head killed entries are popped the same way when they reach the head.
- **Wait counter.**
  - Increments each cycle the FIFO is nonempty and no B issue or kill-pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at `MAX_WAIT`.
- **States.**
  - NORMAL: `stall_req` = 0. Moves to DRAIN when the wait counter reaches `MAX_WAIT`.
  - DRAIN: `stall_req` = 1. Returns to NORMAL in the cycle after the FIFO becomes empty.
  - During DRAIN, port A keeps priority, so in-flight writes are never lost. The pipeline guarantees `a_we` = 0 starting 2 cycles after `stall_req` rises.
- **Full FIFO.** `b_ready` = 0, and the producer holds its data.
- **Simultaneous push and pop while full.** The push is refused, because `b_ready` is derived from the registered count.
- **Wrap-around.** Head and tail pointers wrap modulo `DEPTH`. Occupancy runs 0..`DEPTH`.

## Timing
- Write latency from A request to `rf_we` is 1 cycle.
- Latency from B push to earliest issue is 1 cycle, when the FIFO was empty and `a_we` = 0 in that later cycle.
- `stall_req` is registered. It rises 1 cycle after the counter reaches `MAX_WAIT`.
- Reset values: `rf_we`=0, `rf_addr`=0, `rf_data`=0, `stall_req`=0, `b_ready`=1, `b_count`=0. State is NORMAL, pointers are 0, the counter is 0, and all entries are invalid.
- Reset mid-operation discards queued entries immediately. No partial write is issued after reset deasserts.

## Configuration
- **`RF_ARB_R0_DROP_EN` defined:** writes to address 0 from either port are consumed but never issued.
  - A with `a_addr`=0 produces `rf_we`=0 and does not block the B slot.
  - B entries with address 0 are popped without issue.
- **Undefined:** address 0 is treated like any other register.

## Test plan
- **Priority.** Reset, then `a_we`=1 (addr 3, 0x11) and a B push (addr 4, 0x22) in the same cycle. Required: cycle+1 shows `rf_we`=1 with addr 3, data 0x11; cycle+2 shows addr 4, data 0x22.
- **Full FIFO.** Push 4 B entries while `a_we`=1 continuously. Required: `b_count`=4, `b_ready`=0, and a 5th push is refused. After `a_we` drops, the entries issue in order over 4 cycles and `b_count` returns to 0.
- **Kill.** Queue B (addr 7, 0xAA), then issue A (addr 7, 0xBB). Required: the register file sees only 0xBB at addr 7, and `b_count` returns to 0.
- **Starvation drain (`MAX_WAIT`=8).** Queue 1 B entry and hold `a_we`=1. Required: `stall_req` rises 9 cycles after the push. Once `a_we` drops, the entry issues and `stall_req` falls the cycle after the FIFO empties.
- **Reset mid-operation.** With 3 entries queued and DRAIN active, assert `reset`. Required: all outputs at their reset values immediately, and no write after release.
- **`RF_ARB_R0_DROP_EN`.** A write to addr 0 gives `rf_we`=0. Repeat without the macro: `rf_we`=1 with addr 0.
